line_track_controller: RTL and testbench
========================================

Name: line_track_controller

Overview:
- Closed-loop steering sequencer for the line-follow path.
- Consumes per-frame results (width, centroid x, detected) over a valid/ready handshake and computes the signed centroid error.
- Runs an acquire/track/coast/lost state machine, applies slew-limited proportional steering, and drives left/right motor PWM plus a lost-line alarm.
- Sits downstream of the frame-result CDC, in parallel with the LED/HEX display.

Parameters:
MAX_W, 640, frame width substituted when frame_width==0
KP_SHIFT, 2, steering target = error >>> KP_SHIFT (arithmetic)
BASE_SPEED, 160, nominal duty (0..255) in TRACK
SLEW_STEP, 8, max |change| of steer per accepted frame
ACQ_FRAMES, 3, consecutive detected frames needed to enter TRACK
LOST_FRAMES, 8, consecutive missed frames (counted from COAST entry) to enter LOST

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous, active-low reset
enable  in  1  run control; 0 forces IDLE
frame_valid  in  1  frame result present
frame_ready  out  1  controller can accept a frame
frame_width  in  16  frame width in pixels
frame_cx  in  16  line centroid x, unsigned
frame_detected  in  1  line found in frame
state  out  3  0 IDLE, 1 ACQUIRE, 2 TRACK, 3 COAST, 4 LOST
steer  out  16  signed applied steering value
duty_l  out  8  computed left duty
duty_r  out  8  computed right duty
pwm_l  out  1  left motor PWM
pwm_r  out  1  right motor PWM
lost_alarm  out  1  high while in LOST

Behaviour:
- Reset values: state=IDLE, steer=0, duty_l=duty_r=0, pwm_l=pwm_r=0, lost_alarm=0, all counters 0, frame_ready=0 during reset and 1 on the first clock after release.
- Handshake: a frame is accepted on a cycle where frame_valid && frame_ready. frame_ready drops for the 2 following cycles (the processing pipeline), then returns to 1. Inputs are sampled only on the accept cycle.
- Pipeline:
  - Stage 1 (accept+1): w = (frame_width==0) ? MAX_W : frame_width; err = cx - (w>>1), computed in 17 bits and saturated to 16-bit signed.
  - Stage 2 (accept+2): FSM, steer and duty registers update.
  - state, steer and duty outputs are visible 2 cycles after accept.
- FSM, evaluated at stage 2 only; enable is checked every cycle:
  - IDLE: frames are accepted and discarded. enable=1 → ACQUIRE with acq_cnt=0.
  - ACQUIRE: a detected frame increments acq_cnt; when acq_cnt reaches ACQ_FRAMES → TRACK. An undetected frame clears acq_cnt. steer is held at 0.
  - TRACK: a detected frame updates steer. An undetected frame → COAST with miss_cnt=1.
  - COAST: steer is held. A detected frame → TRACK and updates steer on the same frame. An undetected frame increments miss_cnt; reaching LOST_FRAMES → LOST.
  - LOST: a detected frame → ACQUIRE with acq_cnt=1, steer=0.
  - enable=0 in any state → IDLE on the next clock. steer=0, counters=0, and any frame in the pipeline is discarded with no state update.
- Steering:
  - target = clamp(err >>> KP_SHIFT, -BASE_SPEED, +BASE_SPEED).
  - steer moves toward target by min(|target-steer|, SLEW_STEP) per qualifying frame.
- Duty:
  - speed = BASE_SPEED in TRACK, BASE_SPEED>>1 in COAST, 0 otherwise.
  - duty_l = clamp(speed+steer, 0, 255); duty_r = clamp(speed-steer, 0, 255). Compute in signed 17 bits before clamping.
  - In IDLE, ACQUIRE and LOST both duties are forced to 0.
- PWM:
  - A free-running 8-bit counter drives pwm_x = (cnt < shadow_x).
  - shadow_x loads duty_x only when cnt==255, so the new value applies from the next cnt==0.
  - Duty 0 → pwm never high; duty 255 → high 255 of every 256 cycles.
  - Reset clears cnt and both shadows.
- lost_alarm = (state==LOST), registered with state.

Test Plan:
- Idle: enable=0, 4 frames with detected=1 → all accepted (frame_ready pattern 1,0,0,1), state stays 0, duties 0, pwm low.
- Acquire: enable=1, frames w=640 cx=320 det=1 → state 1 after frames 1 and 2, state 2 exactly 2 cycles after the 3rd accept; steer 0, duty_l=duty_r=160.
- Slew: in TRACK, frames cx=400 (err=80, target=20) → steer 8, 16, 20, 20; final duty_l=180, duty_r=140.
- Width zero / negative: in TRACK, w=0 cx=0 (err=-320, target=-80) → steer decreases by 8 per frame until -80; duty_l=80, duty_r=240.
- Coast/lost: in TRACK with steer=20, send det=0 frames → COAST after 1st (duty_l=100, duty_r=60, steer held), LOST after 8th miss (lost_alarm=1, duties 0); next det=1 frame → state 1.
- PWM/enable: duty_l=64 → pwm_l high for 64 of every 256 cycles; change duty mid-period → new width only after cnt wraps; drop enable 1 cycle after an accept → IDLE next clock, frame discarded, steer=0.

Source files
------------

// File: rtl/line_track_controller.sv
// Line-follow steering sequencer: takes per-frame centroid results, runs the
// acquire/track/coast/lost state machine and drives slew-limited motor PWM.
module line_track_controller #(
    parameter int MAX_W       = 640,
    parameter int KP_SHIFT    = 2,
    parameter int BASE_SPEED  = 160,
    parameter int SLEW_STEP   = 8,
    parameter int ACQ_FRAMES  = 3,
    parameter int LOST_FRAMES = 8
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               enable,
    input  logic               frame_valid,
    output logic               frame_ready,
    input  logic [15:0]        frame_width,
    input  logic [15:0]        frame_cx,
    input  logic               frame_detected,
    output logic [2:0]         state,
    output logic signed [15:0] steer,
    output logic [7:0]         duty_l,
    output logic [7:0]         duty_r,
    output logic               pwm_l,
    output logic               pwm_r,
    output logic               lost_alarm
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ACQUIRE = 3'd1,
        TRACK   = 3'd2,
        COAST   = 3'd3,
        LOST    = 3'd4
    } state_t;

    localparam logic signed [15:0] BASE_S      = 16'(BASE_SPEED);
    localparam logic signed [15:0] NEG_BASE_S  = -BASE_S;
    localparam logic signed [15:0] SLEW_S      = 16'(SLEW_STEP);
    localparam logic signed [16:0] SLEW_17     = 17'(SLEW_STEP);
    localparam logic signed [16:0] NEG_SLEW_17 = -SLEW_17;
    localparam logic signed [16:0] SPD_TRACK   = 17'(BASE_SPEED);
    localparam logic signed [16:0] SPD_COAST   = 17'(BASE_SPEED >> 1);
    localparam logic [7:0]         ACQ_LAST    = 8'(ACQ_FRAMES - 1);
    localparam logic [7:0]         MISS_LAST   = 8'(LOST_FRAMES - 1);

    state_t             cur_state;
    logic               accept;
    logic               s1_valid;
    logic               s1_detected;
    logic signed [15:0] s1_err;
    logic [15:0]        eff_width;
    logic [15:0]        half_width;
    logic signed [16:0] raw_err;
    logic signed [15:0] sat_err;
    logic signed [15:0] shifted;
    logic signed [15:0] target;
    logic signed [16:0] steer_ext;
    logic signed [16:0] steer_diff;
    logic signed [15:0] slewed;
    logic signed [16:0] slewed_ext;
    logic [7:0]         acq_cnt;
    logic [7:0]         miss_cnt;
    logic [7:0]         pwm_cnt;
    logic [7:0]         shadow_l;
    logic [7:0]         shadow_r;

    function automatic logic [7:0] clamp_duty(input logic signed [16:0] sum);
        if (sum < 17'sd0)
            return 8'd0;
        else if (sum > 17'sd255)
            return 8'd255;
        else
            return 8'(sum);
    endfunction

    assign state  = cur_state;
    assign accept = frame_valid && frame_ready;

    assign eff_width  = (frame_width == 16'd0) ? 16'(MAX_W) : frame_width;
    assign half_width = eff_width >> 1;
    assign raw_err    = $signed({1'b0, frame_cx}) - $signed({1'b0, half_width});
    assign sat_err    = (raw_err > 17'sd32767)  ? 16'sh7FFF :
                        (raw_err < -17'sd32768) ? 16'sh8000 : 16'(raw_err);

    // Proportional target, clamped to the base speed, then slew-limited
    assign shifted    = s1_err >>> KP_SHIFT;
    assign target     = (shifted > BASE_S)     ? BASE_S :
                        (shifted < NEG_BASE_S) ? NEG_BASE_S : shifted;
    assign steer_ext  = 17'(steer);
    assign steer_diff = 17'(target) - steer_ext;
    assign slewed     = (steer_diff > SLEW_17)     ? steer + SLEW_S :
                        (steer_diff < NEG_SLEW_17) ? steer - SLEW_S : target;
    assign slewed_ext = 17'(slewed);

    // Stage 1 capture; ready stays low while a frame occupies either stage
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            frame_ready <= 1'b0;
            s1_valid    <= 1'b0;
            s1_detected <= 1'b0;
            s1_err      <= '0;
        end else begin
            frame_ready <= !(accept || s1_valid);
            s1_valid    <= accept;
            if (accept) begin
                s1_detected <= frame_detected;
                s1_err      <= sat_err;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cur_state  <= IDLE;
            steer      <= '0;
            acq_cnt    <= '0;
            miss_cnt   <= '0;
            duty_l     <= '0;
            duty_r     <= '0;
            lost_alarm <= 1'b0;
        end else if (!enable) begin
            cur_state  <= IDLE;
            steer      <= '0;
            acq_cnt    <= '0;
            miss_cnt   <= '0;
            duty_l     <= '0;
            duty_r     <= '0;
            lost_alarm <= 1'b0;
        end else if (cur_state == IDLE) begin
            cur_state <= ACQUIRE;
            acq_cnt   <= '0;
        end else if (s1_valid) begin
            case (cur_state)
                ACQUIRE: begin
                    if (!s1_detected) begin
                        acq_cnt <= '0;
                    end else if (acq_cnt == ACQ_LAST) begin
                        cur_state <= TRACK;
                        acq_cnt   <= '0;
                        duty_l    <= clamp_duty(SPD_TRACK + steer_ext);
                        duty_r    <= clamp_duty(SPD_TRACK - steer_ext);
                    end else begin
                        acq_cnt <= acq_cnt + 8'd1;
                    end
                end
                TRACK: begin
                    if (s1_detected) begin
                        steer  <= slewed;
                        duty_l <= clamp_duty(SPD_TRACK + slewed_ext);
                        duty_r <= clamp_duty(SPD_TRACK - slewed_ext);
                    end else begin
                        cur_state <= COAST;
                        miss_cnt  <= 8'd1;
                        duty_l    <= clamp_duty(SPD_COAST + steer_ext);
                        duty_r    <= clamp_duty(SPD_COAST - steer_ext);
                    end
                end
                COAST: begin
                    if (s1_detected) begin
                        cur_state <= TRACK;
                        miss_cnt  <= '0;
                        steer     <= slewed;
                        duty_l    <= clamp_duty(SPD_TRACK + slewed_ext);
                        duty_r    <= clamp_duty(SPD_TRACK - slewed_ext);
                    end else if (miss_cnt == MISS_LAST) begin
                        cur_state  <= LOST;
                        miss_cnt   <= '0;
                        duty_l     <= '0;
                        duty_r     <= '0;
                        lost_alarm <= 1'b1;
                    end else begin
                        miss_cnt <= miss_cnt + 8'd1;
                    end
                end
                LOST: begin
                    if (s1_detected) begin
                        cur_state  <= ACQUIRE;
                        acq_cnt    <= 8'd1;
                        steer      <= '0;
                        lost_alarm <= 1'b0;
                    end
                end
                default: begin
                    cur_state <= IDLE;
                end
            endcase
        end
    end

    // Shadows reload only at the period end so a duty change never truncates a pulse
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pwm_cnt  <= '0;
            shadow_l <= '0;
            shadow_r <= '0;
            pwm_l    <= 1'b0;
            pwm_r    <= 1'b0;
        end else begin
            pwm_cnt <= pwm_cnt + 8'd1;
            if (pwm_cnt == 8'd255) begin
                shadow_l <= duty_l;
                shadow_r <= duty_r;
            end
            pwm_l <= (pwm_cnt < shadow_l);
            pwm_r <= (pwm_cnt < shadow_r);
        end
    end

endmodule

// File: tb/tb_line_track_controller.sv
// Directed bench for line_track_controller: handshake, acquire, slew,
// coast/lost, PWM period behaviour and enable drop.
module tb_line_track_controller;

    logic               clk;
    logic               reset_n;
    logic               enable;
    logic               frame_valid;
    logic               frame_ready;
    logic [15:0]        frame_width;
    logic [15:0]        frame_cx;
    logic               frame_detected;
    logic [2:0]         state;
    logic signed [15:0] steer;
    logic [7:0]         duty_l;
    logic [7:0]         duty_r;
    logic               pwm_l;
    logic               pwm_r;
    logic               lost_alarm;

    int checks = 0;
    int errors = 0;
    int hi_l;
    int hi_r;

    line_track_controller dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .enable         (enable),
        .frame_valid    (frame_valid),
        .frame_ready    (frame_ready),
        .frame_width    (frame_width),
        .frame_cx       (frame_cx),
        .frame_detected (frame_detected),
        .state          (state),
        .steer          (steer),
        .duty_l         (duty_l),
        .duty_r         (duty_r),
        .pwm_l          (pwm_l),
        .pwm_r          (pwm_r),
        .lost_alarm     (lost_alarm)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Returns on the falling edge of the cycle after the accept
    task automatic applyStimulus(input logic [15:0] w, input logic [15:0] cx, input logic det);
        int waits = 0;
        @(negedge clk);
        while (!frame_ready && waits < 20) begin
            @(negedge clk);
            waits++;
        end
        if (!frame_ready)
            checkOutput("ready_timeout", int'(frame_ready), 1);
        frame_valid    = 1'b1;
        frame_width    = w;
        frame_cx       = cx;
        frame_detected = det;
        @(negedge clk);
        frame_valid = 1'b0;
    endtask

    task automatic findRise();
        logic prev;
        logic found = 1'b0;
        prev = pwm_l;
        for (int i = 0; i < 600 && !found; i++) begin
            @(negedge clk);
            if (pwm_l && !prev)
                found = 1'b1;
            prev = pwm_l;
        end
        if (!found)
            checkOutput("pwm_rise_timeout", int'(found), 1);
    endtask

    initial begin
        reset_n        = 1'b0;
        enable         = 1'b0;
        frame_valid    = 1'b0;
        frame_width    = '0;
        frame_cx       = '0;
        frame_detected = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("rst_ready", int'(frame_ready), 0);
        checkOutput("rst_state", int'(state), 0);
        checkOutput("rst_steer", $signed(steer), 0);
        checkOutput("rst_duty_l", int'(duty_l), 0);
        checkOutput("rst_duty_r", int'(duty_r), 0);
        checkOutput("rst_pwm", int'({pwm_l, pwm_r}), 0);
        checkOutput("rst_alarm", int'(lost_alarm), 0);
        reset_n = 1'b1;
        @(negedge clk);
        checkOutput("ready_after_rst", int'(frame_ready), 1);

        // Idle: frames accepted and discarded
        applyStimulus(16'd640, 16'd320, 1'b1);
        checkOutput("idle_ready_t1", int'(frame_ready), 0);
        @(negedge clk);
        checkOutput("idle_ready_t2", int'(frame_ready), 0);
        @(negedge clk);
        checkOutput("idle_ready_t3", int'(frame_ready), 1);
        for (int i = 0; i < 3; i++)
            applyStimulus(16'd640, 16'd320, 1'b1);
        @(negedge clk);
        checkOutput("idle_state", int'(state), 0);
        checkOutput("idle_duty", int'({duty_l, duty_r}), 0);
        hi_l = 0;
        hi_r = 0;
        repeat (256) begin
            @(negedge clk);
            hi_l += int'(pwm_l);
            hi_r += int'(pwm_r);
        end
        checkOutput("idle_pwm_l_high", hi_l, 0);
        checkOutput("idle_pwm_r_high", hi_r, 0);

        // Acquire
        enable = 1'b1;
        repeat (3) @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            applyStimulus(16'd640, 16'd320, 1'b1);
            @(negedge clk);
            checkOutput("acq_state", int'(state), 1);
        end
        applyStimulus(16'd640, 16'd320, 1'b1);
        checkOutput("acq3_state_early", int'(state), 1);
        @(negedge clk);
        checkOutput("acq3_state", int'(state), 2);
        checkOutput("acq3_steer", $signed(steer), 0);
        checkOutput("acq3_duty_l", int'(duty_l), 160);
        checkOutput("acq3_duty_r", int'(duty_r), 160);

        // Slew toward target 20
        for (int i = 1; i <= 4; i++) begin
            applyStimulus(16'd640, 16'd400, 1'b1);
            @(negedge clk);
            checkOutput("slew_steer", $signed(steer), (i * 8 > 20) ? 20 : i * 8);
        end
        checkOutput("slew_duty_l", int'(duty_l), 180);
        checkOutput("slew_duty_r", int'(duty_r), 140);

        // Coast then lost
        applyStimulus(16'd640, 16'd400, 1'b0);
        @(negedge clk);
        checkOutput("coast_state", int'(state), 3);
        checkOutput("coast_steer", $signed(steer), 20);
        checkOutput("coast_duty_l", int'(duty_l), 100);
        checkOutput("coast_duty_r", int'(duty_r), 60);
        for (int i = 2; i <= 8; i++) begin
            applyStimulus(16'd640, 16'd400, 1'b0);
            @(negedge clk);
            checkOutput("miss_state", int'(state), (i == 8) ? 4 : 3);
        end
        checkOutput("lost_alarm", int'(lost_alarm), 1);
        checkOutput("lost_duty", int'({duty_l, duty_r}), 0);
        applyStimulus(16'd640, 16'd320, 1'b1);
        @(negedge clk);
        checkOutput("relock_state", int'(state), 1);
        checkOutput("relock_alarm", int'(lost_alarm), 0);
        checkOutput("relock_steer", $signed(steer), 0);
        applyStimulus(16'd640, 16'd320, 1'b1);
        @(negedge clk);
        checkOutput("relock2_state", int'(state), 1);
        applyStimulus(16'd640, 16'd320, 1'b1);
        @(negedge clk);
        checkOutput("relock3_state", int'(state), 2);

        // Zero width substitutes 640; target -80
        for (int i = 1; i <= 11; i++) begin
            applyStimulus(16'd0, 16'd0, 1'b1);
            @(negedge clk);
            checkOutput("neg_steer", $signed(steer), (i * 8 > 80) ? -80 : -(i * 8));
        end
        checkOutput("neg_duty_l", int'(duty_l), 80);
        checkOutput("neg_duty_r", int'(duty_r), 240);

        // w=1000 cx=116: err -384, target -96; right duty saturates at 255
        applyStimulus(16'd1000, 16'd116, 1'b1);
        applyStimulus(16'd1000, 16'd116, 1'b1);
        @(negedge clk);
        checkOutput("d64_steer", $signed(steer), -96);
        checkOutput("d64_duty_l", int'(duty_l), 64);
        checkOutput("d64_duty_r", int'(duty_r), 255);

        repeat (300) @(negedge clk);
        findRise();
        hi_l = int'(pwm_l);
        hi_r = int'(pwm_r);
        repeat (255) begin
            @(negedge clk);
            hi_l += int'(pwm_l);
            hi_r += int'(pwm_r);
        end
        checkOutput("pwm_l_64", hi_l, 64);
        checkOutput("pwm_r_255", hi_r, 255);

        // Duty change early in a period must wait for the wrap
        findRise();
        hi_l = int'(pwm_l);
        fork
            begin
                repeat (255) begin
                    @(negedge clk);
                    hi_l += int'(pwm_l);
                end
            end
            begin
                repeat (8) @(negedge clk);
                applyStimulus(16'd640, 16'd400, 1'b1);
            end
        join
        checkOutput("pwm_l_old_period", hi_l, 64);
        checkOutput("mid_duty_l", int'(duty_l), 72);
        hi_l = 0;
        repeat (256) begin
            @(negedge clk);
            hi_l += int'(pwm_l);
        end
        checkOutput("pwm_l_new_period", hi_l, 72);

        // Enable drop one cycle after an accept
        applyStimulus(16'd640, 16'd400, 1'b1);
        enable = 1'b0;
        @(negedge clk);
        checkOutput("dis_state", int'(state), 0);
        checkOutput("dis_steer", $signed(steer), 0);
        checkOutput("dis_duty", int'({duty_l, duty_r}), 0);
        checkOutput("dis_alarm", int'(lost_alarm), 0);
        @(negedge clk);
        checkOutput("dis_steer_hold", $signed(steer), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
